// File: rtl/as_regfile_sb.sv
// Integer register file with two combinational read ports and a pending-write scoreboard.
// Optional write-first bypass of the write-back port is enabled by defining AS_REGFILE_BYPASS_EN.
module as_regfile_sb #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned ADDR_W = 5,
  localparam int unsigned NREGS  = 2**ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [NREGS-1:0]  pending_o
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending_q;
  logic [NREGS-1:0]  pending_d;
  logic [NREGS-1:0]  eff_pending;
  logic              wb_live;

  assign wb_live = wb_we_i && (wb_rd_i != '0);

  // Architectural state; index 0 is never written so it stays zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wb_live) begin
      regs[wb_rd_i] <= wb_data_i;
    end
  end

  // Scoreboard next state: flush beats issue, a new issue beats a retiring write-back.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      if (wb_we_i) begin
        pending_d[wb_rd_i] = 1'b0;
      end
      if (issue_i) begin
        pending_d[issue_rd_i] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

  // Read ports and hazard detection.
  always_comb begin
    rd1_o       = (rs1_i == '0) ? '0 : regs[rs1_i];
    rd2_o       = (rs2_i == '0) ? '0 : regs[rs2_i];
    eff_pending = pending_q;
`ifdef AS_REGFILE_BYPASS_EN
    if (wb_live && (wb_rd_i == rs1_i)) begin
      rd1_o = wb_data_i;
    end
    if (wb_live && (wb_rd_i == rs2_i)) begin
      rd2_o = wb_data_i;
    end
    if (wb_live) begin
      eff_pending[wb_rd_i] = 1'b0;
    end
`endif
    stall_o = eff_pending[rs1_i] | eff_pending[rs2_i];
  end

endmodule

// File: tb/tb_as_regfile_sb.sv
// Self-checking bench for as_regfile_sb: directed scenarios plus randomized traffic
// checked every cycle against a behavioural register-file/scoreboard model.
module tb_as_regfile_sb;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              wb_we_i = 1'b0;
  logic [ADDR_W-1:0] wb_rd_i = '0;
  logic [DATA_W-1:0] wb_data_i = '0;
  logic [ADDR_W-1:0] rs1_i = '0;
  logic [ADDR_W-1:0] rs2_i = '0;
  logic [DATA_W-1:0] rd1_o;
  logic [DATA_W-1:0] rd2_o;
  logic              issue_i = 1'b0;
  logic [ADDR_W-1:0] issue_rd_i = '0;
  logic              flush_i = 1'b0;
  logic              stall_o;
  logic [NREGS-1:0]  pending_o;

  as_regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
    .wb_data_i(wb_data_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd1_o(rd1_o),
    .rd2_o(rd2_o), .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .flush_i(flush_i), .stall_o(stall_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

`ifdef AS_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Behavioural model: architectural values and the set of registers awaiting a producer.
  logic [DATA_W-1:0] m_regs [NREGS];
  bit   [NREGS-1:0]  m_pend;
  bit                chk_en = 1'b0;
  int                n_checks = 0;
  int                n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_read(input int rs);
    if (rs == 0) return '0;
    if (BYPASS && wb_we_i && int'(wb_rd_i) == rs) return wb_data_i;
    return m_regs[rs];
  endfunction

  function automatic bit exp_busy(input int rs);
    if (rs == 0) return 1'b0;
    if (BYPASS && wb_we_i && int'(wb_rd_i) == rs) return 1'b0;
    return m_pend[rs];
  endfunction

  task automatic compare_all();
    if (!chk_en) return;
    chk("rd1", rd1_o, exp_read(int'(rs1_i)));
    chk("rd2", rd2_o, exp_read(int'(rs2_i)));
    chk("stall", 64'(stall_o), 64'(exp_busy(int'(rs1_i)) | exp_busy(int'(rs2_i))));
    chk("pending", 64'(pending_o), 64'(m_pend));
  endtask

  task automatic model_update();
    if (rst_i) begin
      for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
      m_pend = '0;
      return;
    end
    if (wb_we_i && wb_rd_i != 0) m_regs[wb_rd_i] = wb_data_i;
    if (flush_i) begin
      m_pend = '0;
    end else begin
      if (wb_we_i) m_pend[wb_rd_i] = 1'b0;
      if (issue_i && issue_rd_i != 0) m_pend[issue_rd_i] = 1'b1;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst_i = 1'b0; wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    issue_i = 1'b0; issue_rd_i = '0; flush_i = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(NREGS); i++) m_regs[i] = 'x;
    m_pend = '0;
    @(posedge clk);
    #1;

    // Reset and x0
    rst_i = 1'b1;
    step();
    chk_en = 1'b1;
    idle(); rs1_i = 5'd5; rs2_i = 5'd31; settle();
    chk("rst_rd1", rd1_o, 64'h0);
    chk("rst_rd2", rd2_o, 64'h0);
    chk("rst_stall", 64'(stall_o), 64'h0);
    chk("rst_pending", 64'(pending_o), 64'h0);
    step();
    wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 64'hDEAD; rs1_i = 5'd0; settle();
    chk("x0_wr_same", rd1_o, 64'h0);
    step();
    idle(); rs1_i = 5'd0; settle();
    chk("x0_rd", rd1_o, 64'h0);
    step();

    // Basic write/read
    wb_we_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 64'h0123_4567_89AB_CDEF;
    step();
    idle(); rs1_i = 5'd7; rs2_i = 5'd7; settle();
    chk("r7_rd1", rd1_o, 64'h0123_4567_89AB_CDEF);
    chk("r7_rd2", rd2_o, 64'h0123_4567_89AB_CDEF);
    step();

    // Scoreboard RAW
    issue_i = 1'b1; issue_rd_i = 5'd3; rs1_i = 5'd0; rs2_i = 5'd0;
    step();
    idle(); rs2_i = 5'd3; settle();
    chk("raw_stall", 64'(stall_o), 64'h1);
    chk("raw_pend3", 64'(pending_o[3]), 64'h1);
    step();
    wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 64'h55; settle();
    chk("wb_stall", 64'(stall_o), BYPASS ? 64'h0 : 64'h1);
    if (BYPASS) chk("wb_byp_rd2", rd2_o, 64'h55);
    step();
    idle(); rs2_i = 5'd3; settle();
    chk("after_wb_stall", 64'(stall_o), 64'h0);
    chk("after_wb_rd2", rd2_o, 64'h55);
    chk("after_wb_pend", 64'(pending_o), 64'h0);
    step();

    // Simultaneous issue and write-back to the same register
    issue_i = 1'b1; issue_rd_i = 5'd9;
    step();
    wb_we_i = 1'b1; wb_rd_i = 5'd9; wb_data_i = 64'h99;
    step();
    idle(); rs1_i = 5'd9; rs2_i = 5'd0; settle();
    chk("r9_rd1", rd1_o, 64'h99);
    chk("r9_pend", 64'(pending_o), 64'h0000_0200);
    step();

    // Flush discards all marks and a same-cycle issue
    issue_i = 1'b1; issue_rd_i = 5'd4; step();
    issue_rd_i = 5'd8; step();
    issue_rd_i = 5'd12; step();
    idle(); settle();
    chk("pre_flush_pend", 64'(pending_o), 64'h0000_1310);
    flush_i = 1'b1; issue_i = 1'b1; issue_rd_i = 5'd10;
    step();
    idle(); settle();
    chk("flush_pend", 64'(pending_o), 64'h0);
    step();

    // Reset mid-operation discards the write
    issue_i = 1'b1; issue_rd_i = 5'd6; step();
    rst_i = 1'b1; wb_we_i = 1'b1; wb_rd_i = 5'd6; wb_data_i = 64'hAA; issue_i = 1'b1; issue_rd_i = 5'd5;
    step();
    idle(); rs1_i = 5'd6; rs2_i = 5'd7; settle();
    chk("rst_mid_rd1", rd1_o, 64'h0);
    chk("rst_mid_rd2", rd2_o, 64'h0);
    chk("rst_mid_pend", 64'(pending_o), 64'h0);
    step();

    // Randomized traffic concentrated on a few registers to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      rst_i      = ($urandom_range(0, 199) == 0);
      wb_we_i    = $urandom_range(0, 1) == 1;
      wb_rd_i    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb_data_i  = {$urandom, $urandom};
      issue_i    = $urandom_range(0, 1) == 1;
      issue_rd_i = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      flush_i    = ($urandom_range(0, 31) == 0);
      rs1_i      = ($urandom_range(0, 1) == 0) ? wb_rd_i : 5'($urandom_range(0, 7));
      rs2_i      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
